// File: rtl/debug_state_sender_pkg.sv
// Shared definitions for the debug state sender.
//
// Holds the frame header, the frame lengths with and without the trailing
// checksum byte, the snapshot word counts and the sender state encoding.
// The checksum variant is selected by the DEBUG_TX_CHECKSUM_EN macro in
// debug_state_sender.sv; both lengths live here so either build can use them.
package debug_state_sender_pkg;

    localparam logic [7:0] FRAME_HEADER = 8'hA5;

    localparam int PC_W          = 10;
    localparam int WORD_W        = 32;
    localparam int NUM_REGS      = 32;
    localparam int NUM_MEM_WORDS = 10;

    // Snapshot words in frame order: PC, reg0..reg31, mem0..mem9.
    localparam int SNAP_WORDS = 1 + NUM_REGS + NUM_MEM_WORDS;

    // Header + seq + 4 bytes per snapshot word, optional checksum byte.
    localparam int FRAME_LEN_BASE = 2 + 4 * SNAP_WORDS;
    localparam int FRAME_LEN_CSUM = FRAME_LEN_BASE + 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_SEND    = 3'd2,
        ST_GAP     = 3'd3,
        ST_DONE    = 3'd4
    } senderState_t;

endpackage

// File: rtl/debug_frame_mux.sv
// Combinational frame byte selector.
//
// Maps a byte index to the byte of the frame built from the snapshot:
// index 0 is the header, 1 the sequence number, then every snapshot word
// (PC, registers, memory) MSB first. Indices past the snapshot give 0x00.
//
// Ports:
//   byteIdx   in  8     byte index within the frame
//   seq       in  8     frame sequence number
//   pcSnap    in  32    captured PC, zero extended
//   regSnap   in  1024  captured register file
//   memSnap   in  320   captured data memory words
//   frameByte out 8     selected frame byte
module debug_frame_mux
    import debug_state_sender_pkg::*;
(
    input  logic [7:0]                     byteIdx,
    input  logic [7:0]                     seq,
    input  logic [WORD_W-1:0]              pcSnap,
    input  logic [NUM_REGS*WORD_W-1:0]     regSnap,
    input  logic [NUM_MEM_WORDS*WORD_W-1:0] memSnap,
    output logic [7:0]                     frameByte
);

    logic [SNAP_WORDS*WORD_W-1:0] frameWords;
    logic [7:0]  wordOff;
    logic [5:0]  wordSel;
    logic [1:0]  byteSel;
    logic [10:0] bitOff;

    // Word k of the flattened snapshot sits at bits [32k+31:32k].
    assign frameWords = {memSnap, regSnap, pcSnap};

    always_comb begin
        wordOff = byteIdx - 8'd2;
        wordSel = wordOff[7:2];
        byteSel = wordOff[1:0];
        // word*32 + (3-byteSel)*8: MSB of each word goes out first.
        bitOff  = {wordSel, ~byteSel, 3'b000};

        frameByte = 8'h00;
        if (byteIdx == 8'd0) begin
            frameByte = FRAME_HEADER;
        end else if (byteIdx == 8'd1) begin
            frameByte = seq;
        end else if (wordSel < 6'(SNAP_WORDS)) begin
            frameByte = frameWords[bitOff +: 8];
        end
    end

endmodule

// File: rtl/debug_state_sender.sv
// Debug state sender: on request, snapshots PC, register file and data
// memory and streams them as a byte frame into a UART TX FIFO.
//
// Frame: 0xA5, seq, PC, reg0..reg31, mem0..mem9 (32-bit words, MSB first).
// Build option DEBUG_TX_CHECKSUM_EN appends the XOR of all preceding bytes
// as a final byte; without it no checksum logic exists.
//
// State | meaning
// IDLE    | waiting for sendSignal
// CAPTURE | latch PC/Registers/Memorias into snapshot, clear byte index
// SEND    | write frame[idx] when the FIFO is not full
// GAP     | spacer cycle so tx_full settles; advance index or finish
// DONE    | pulse dataSent, bump sequence counter
//
// Ports:
//   clock      in  1     system clock, rising edge
//   reset      in  1     synchronous active-high reset
//   sendSignal in  1     frame request (ignored unless idle)
//   PC         in  10    pipeline PC
//   Registers  in  1024  register file, reg N at [32N+31:32N]
//   Memorias   in  320   data memory words 0..9
//   tx_full    in  1     UART TX FIFO full
//   wr_uart    out 1     FIFO write strobe
//   w_data     out 8     byte written with wr_uart
//   dataSent   out 1     frame complete pulse
//   busy       out 1     frame in progress (capture through done)
module debug_state_sender
    import debug_state_sender_pkg::*;
(
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             sendSignal,
    input  logic [PC_W-1:0]                  PC,
    input  logic [NUM_REGS*WORD_W-1:0]       Registers,
    input  logic [NUM_MEM_WORDS*WORD_W-1:0]  Memorias,
    input  logic                             tx_full,
    output logic                             wr_uart,
    output logic [7:0]                       w_data,
    output logic                             dataSent,
    output logic                             busy
);

`ifdef DEBUG_TX_CHECKSUM_EN
    localparam int FRAME_LEN = FRAME_LEN_CSUM;
`else
    localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    senderState_t state;
    senderState_t nextState;

    logic [7:0]                        byteIdx;
    logic [7:0]                        seqCnt;
    logic [WORD_W-1:0]                 pcSnap;
    logic [NUM_REGS*WORD_W-1:0]        regSnap;
    logic [NUM_MEM_WORDS*WORD_W-1:0]   memSnap;
    logic [7:0]                        muxByte;
    logic [7:0]                        txByte;

    debug_frame_mux uFrameMux (
        .byteIdx   (byteIdx),
        .seq       (seqCnt),
        .pcSnap    (pcSnap),
        .regSnap   (regSnap),
        .memSnap   (memSnap),
        .frameByte (muxByte)
    );

`ifdef DEBUG_TX_CHECKSUM_EN
    logic [7:0] checksum;

    always_ff @(posedge clock) begin
        if (reset) begin
            checksum <= '0;
        end else if (state == ST_CAPTURE) begin
            checksum <= '0;
        end else if (state == ST_SEND && !tx_full) begin
            checksum <= checksum ^ txByte;
        end
    end

    // The checksum slot replaces the mux output at the final index.
    assign txByte = (byteIdx == LAST_IDX) ? checksum : muxByte;
`else
    assign txByte = muxByte;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE:    if (sendSignal) nextState = ST_CAPTURE;
            ST_CAPTURE: nextState = ST_SEND;
            ST_SEND:    if (!tx_full) nextState = ST_GAP;
            ST_GAP:     nextState = (byteIdx == LAST_IDX) ? ST_DONE : ST_SEND;
            ST_DONE:    nextState = ST_IDLE;
            default:    nextState = ST_IDLE;
        endcase
    end

    // Outputs are forced low while reset is asserted so an aborted frame
    // produces no further writes even in the cycle reset is first seen.
    always_comb begin
        wr_uart  = 1'b0;
        w_data   = 8'h00;
        dataSent = 1'b0;
        busy     = 1'b0;
        if (!reset) begin
            busy = (state != ST_IDLE);
            case (state)
                ST_SEND: begin
                    if (!tx_full) begin
                        wr_uart = 1'b1;
                        w_data  = txByte;
                    end
                end
                ST_DONE: dataSent = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            byteIdx <= '0;
            seqCnt  <= '0;
            pcSnap  <= '0;
            regSnap <= '0;
            memSnap <= '0;
        end else begin
            case (state)
                ST_CAPTURE: begin
                    pcSnap  <= {{(WORD_W-PC_W){1'b0}}, PC};
                    regSnap <= Registers;
                    memSnap <= Memorias;
                    byteIdx <= '0;
                end
                ST_GAP: begin
                    if (byteIdx != LAST_IDX) byteIdx <= byteIdx + 8'd1;
                end
                ST_DONE: seqCnt <= seqCnt + 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_state_sender.sv
module tb_debug_state_sender;

`ifdef DEBUG_TX_CHECKSUM_EN
    localparam int FLEN = 175;
    localparam int BUSY_NOM = 352;
`else
    localparam int FLEN = 174;
    localparam int BUSY_NOM = 350;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          sendSignal = 1'b0;
    logic [9:0]    PC = '0;
    logic [1023:0] Registers = '0;
    logic [319:0]  Memorias = '0;
    logic          tx_full = 1'b0;
    logic          wr_uart;
    logic [7:0]    w_data;
    logic          dataSent;
    logic          busy;

    debug_state_sender dut (
        .clock      (clock),
        .reset      (reset),
        .sendSignal (sendSignal),
        .PC         (PC),
        .Registers  (Registers),
        .Memorias   (Memorias),
        .tx_full    (tx_full),
        .wr_uart    (wr_uart),
        .w_data     (w_data),
        .dataSent   (dataSent),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int nTests = 0;
    int nFail = 0;
    logic [7:0] expQ[$];
    logic [7:0] actQ[$];
    logic [7:0] modelSeq = 8'h00;
    int sentCount = 0;
    int doneCount = 0;
    int busyCnt = 0;
    int lastBusy = 0;
    bit frameOpen = 0;
    bit prevWr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected frame from the current inputs and the model sequence number.
    task automatic buildFrame();
        logic [31:0] w;
        logic [7:0]  b;
        logic [7:0]  x;
        expQ.delete();
        expQ.push_back(8'hA5);
        expQ.push_back(modelSeq);
        x = 8'hA5 ^ modelSeq;
        for (int k = 0; k < 43; k++) begin
            if (k == 0)       w = {22'b0, PC};
            else if (k <= 32) w = Registers[32*(k-1) +: 32];
            else              w = Memorias[32*(k-33) +: 32];
            for (int j = 3; j >= 0; j--) begin
                b = w[8*j +: 8];
                expQ.push_back(b);
                x = x ^ b;
            end
        end
`ifdef DEBUG_TX_CHECKSUM_EN
        expQ.push_back(x);
`endif
    endtask

    // Compare process: every write against the model, protocol rules, done.
    always @(negedge clock) begin
        if (reset) begin
            if (wr_uart || dataSent) begin
                nTests++;
                nFail++;
                $display("FAIL reset_quiet: wr_uart=%0b dataSent=%0b, expected 0 0", wr_uart, dataSent);
            end
            prevWr = 0;
            busyCnt = 0;
        end else begin
            if (wr_uart) begin
                nTests++;
                if (tx_full || prevWr) begin
                    nFail++;
                    $display("FAIL write_rule: tx_full=%0b prevWr=%0b, expected 0 0", tx_full, prevWr);
                end
                nTests++;
                if (expQ.size() == 0) begin
                    nFail++;
                    $display("FAIL unexpected_write: got 0x%0h, expected no write", w_data);
                end else begin
                    logic [7:0] e;
                    e = expQ.pop_front();
                    if (w_data !== e) begin
                        nFail++;
                        $display("FAIL byte[%0d]: got 0x%0h, expected 0x%0h", sentCount, w_data, e);
                    end
                end
                actQ.push_back(w_data);
                sentCount++;
            end
            if (busy) busyCnt++;
            if (dataSent) begin
                nTests++;
                if (!frameOpen || expQ.size() != 0) begin
                    nFail++;
                    $display("FAIL dataSent: open=%0b remaining=%0d, expected 1 0", frameOpen, expQ.size());
                end
                doneCount++;
                lastBusy = busyCnt;
                busyCnt = 0;
                frameOpen = 0;
            end
            prevWr = wr_uart;
        end
    end

    task automatic startFrame();
        @(posedge clock); #1;
        buildFrame();
        actQ.delete();
        sentCount = 0;
        frameOpen = 1;
        sendSignal = 1'b1;
        @(posedge clock); #1;
        sendSignal = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic waitDone(input int base);
        bit seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clock); #1;
            if (doneCount != base) seen = 1;
        end
        check("done_seen", 32'(seen), 32'd1);
        if (seen) modelSeq = modelSeq + 8'd1;
    endtask

    task automatic waitSent(input int n);
        for (int i = 0; i < 1000 && sentCount < n; i++) begin
            @(negedge clock); #1;
        end
        check("reach_idx", sentCount, n);
    endtask

    task automatic runFrame();
        int base;
        base = doneCount;
        startFrame();
        waitDone(base);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", nTests, nFail + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] lit [14];
        int base;
        lit = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock); #1;
        check("rst_wr_uart", 32'(wr_uart), 0);
        check("rst_w_data", 32'(w_data), 0);
        check("rst_dataSent", 32'(dataSent), 0);
        check("rst_busy", 32'(busy), 0);

        // Basic frame; inputs change mid-frame and must not leak in.
        PC = 10'h004;
        Registers[32 +: 32] = 32'h11223344;
        base = doneCount;
        startFrame();
        check("busy_in_frame", 32'(busy), 1);
        repeat (20) @(posedge clock);
        #1;
        PC = 10'h3FF;
        Registers[32 +: 32] = 32'hFFFFFFFF;
        Memorias[0 +: 32] = 32'h55AA55AA;
        waitDone(base);
        repeat (5) @(negedge clock);
        #1;
        check("frame1_len", actQ.size(), FLEN);
        for (int i = 0; i < 14; i++) check("frame1_lit", 32'(actQ[i]), 32'(lit[i]));
        check("frame1_done_once", doneCount - base, 1);
        check("frame1_time", lastBusy, BUSY_NOM);
        check("idle_busy", 32'(busy), 0);

        // FIFO full for 10 cycles while idx 50 is pending.
        PC = 10'h155;
        Registers = '0;
        Memorias = '0;
        Registers[31*32 +: 32] = 32'hCAFEF00D;
        Memorias[3*32 +: 32] = 32'hDEADBEEF;
        base = doneCount;
        startFrame();
        waitSent(50);
        @(posedge clock); #1;
        tx_full = 1'b1;
        repeat (10) @(posedge clock);
        check("stall_hold", sentCount, 50);
        #1 tx_full = 1'b0;
        waitDone(base);
        check("stall_len", actQ.size(), FLEN);
        check("stall_time", lastBusy, BUSY_NOM + 9);

        // Request during a frame is dropped; next request gets seq 3.
        base = doneCount;
        startFrame();
        repeat (30) @(posedge clock);
        #1 sendSignal = 1'b1;
        @(posedge clock); #1 sendSignal = 1'b0;
        waitDone(base);
        repeat (10) @(negedge clock);
        #1;
        check("ignored_req", doneCount - base, 1);
        runFrame();
        check("seq_after_ignore", 32'(actQ[1]), 32'h03);

        // Reset at idx 20 aborts the frame.
        base = doneCount;
        startFrame();
        waitSent(20);
        @(posedge clock); #1;
        reset = 1'b1;
        expQ.delete();
        frameOpen = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        modelSeq = 8'h00;
        @(negedge clock); #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_wr", 32'(wr_uart), 0);
        repeat (400) @(posedge clock);
        #1;
        check("abort_no_done", doneCount - base, 0);
        check("abort_sent", sentCount, 20);

        // All-zero snapshot, first frame after reset.
        PC = '0;
        Registers = '0;
        Memorias = '0;
        runFrame();
        check("zero_len", actQ.size(), FLEN);
        check("zero_seq", 32'(actQ[1]), 32'h00);
`ifdef DEBUG_TX_CHECKSUM_EN
        check("zero_csum", 32'(actQ[FLEN-1]), 32'hA5);
`endif

        // Frames 2..256 after reset, then frame 257 must carry seq 0.
        for (int f = 2; f <= 256; f++) begin
            PC = 10'($urandom);
            Registers[32*(f % 32) +: 32] = $urandom;
            Memorias[32*(f % 10) +: 32] = $urandom;
            runFrame();
        end
        check("seq_255", 32'(actQ[1]), 32'hFF);
        runFrame();
        check("seq_wrap", 32'(actQ[1]), 32'h00);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
